bcd_seq_divider: RTL
====================

Name: bcd_seq_divider

Overview:
- Multi-cycle BCD divider between the operand registers (A/B, two BCD digits each, keypad-entered) and the 7-segment display mux.
- On a one-cycle start pulse it captures A and B, converts them to binary, runs a restoring division, and converts quotient and remainder back to two-digit BCD.
- Signals completion with a done pulse and holds its results for the display.

Parameters:
- BLANK_CODE, 4'hF, digit code meaning "not entered"; treated as value 0 on input and used to blank outputs on error.
- Q_BITS, 7, binary width of dividend, divisor, quotient and remainder (0..99 fits); also the divide-loop iteration count.

Ports:
- clk  in  1  system clock (27 MHz).
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- a_bcd  in  8  dividend {tens, units}, BCD.
- b_bcd  in  8  divisor {tens, units}, BCD.
- q_bcd  out  8  quotient {tens, units}, BCD.
- r_bcd  out  8  remainder {tens, units}, BCD.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; results valid and stable from this cycle.
- div_zero  out  1  sticky error: last operation had divisor 0.
- bad_digit  out  1  sticky error: last operation had an operand digit in 4'hA..4'hE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE.
  - q_bcd = r_bcd = {BLANK_CODE, BLANK_CODE}.
  - busy = done = div_zero = bad_digit = 0.
  - Reset wins over any in-flight operation; no partial result reaches the outputs.
- FSM states: IDLE, LOAD, DIV, CONV, DONE.
- IDLE:
  - start = 1 captures a_bcd and b_bcd into internal registers and moves to LOAD.
  - Operand changes after capture have no effect.
- LOAD (1 cycle):
  - Each digit equal to BLANK_CODE is taken as 0.
  - Binary value = tens*10 + units.
  - Any digit in 4'hA..4'hE sets bad_digit and goes to DONE.
  - Otherwise, divisor 0 sets div_zero and goes to DONE.
  - Otherwise, clears both error flags, loads the dividend/divisor and goes to DIV.
- DIV (exactly Q_BITS cycles):
  - One restoring step per cycle, MSB first.
  - Partial remainder is Q_BITS+1 bits wide; subtract, keep when non-negative, shift a quotient bit in.
  - After the last step, goes to CONV.
- CONV (exactly Q_BITS cycles):
  - Double-dabble conversion of quotient and remainder in parallel, one shift per cycle with add-3 correction.
  - Goes to DONE.
- DONE (1 cycle):
  - done = 1; q_bcd and r_bcd update on entry to DONE.
  - On error, both outputs are {BLANK_CODE, BLANK_CODE}.
  - Then returns to IDLE.
- Latency with start high in cycle k (Q_BITS = 7):
  - Normal: LOAD k+1, DIV k+2..k+8, CONV k+9..k+15, done in k+16.
  - Error path: done in k+2.
- start while busy is ignored and not queued. start in the DONE cycle is also ignored; earliest accept is the IDLE cycle after DONE.
- Outputs and error flags hold their values until the next DONE or reset.
- BCD outputs always hold tens in [7:4] and units in [3:0]. Quotient ≤ 99 and remainder < divisor ≤ 99, so no overflow is possible.

Optional Feature:
- Macro BCD_DIV_EARLY_EXIT_EN.
- When defined:
  - In LOAD, if the valid dividend < divisor, the DIV state is skipped: quotient = 0, remainder = dividend, go straight to CONV. done then arrives at k+9.
  - Dividend = 0 with nonzero divisor also takes this path.
- When undefined: every non-error operation takes the full fixed latency (done at k+16).

Test Plan:
- Normal divide: a=8'h87, b=8'h05, start at k → busy k+1..k+16, done only at k+16, q_bcd=8'h17, r_bcd=8'h02, both error flags 0.
- Blank digits: a=8'hF3, b=8'hF2 → q_bcd=8'h01, r_bcd=8'h01. Also a=8'h99, b=8'h01 → q=8'h99, r=8'h00.
- Errors:
  - b=8'hFF (blank = 0) → done at k+2, div_zero=1, q=r=8'hFF.
  - Next op a=8'h1C → bad_digit=1, div_zero=0.
  - Next valid op clears both flags.
- Dividend smaller than divisor: a=8'h07, b=8'h09 → q=8'h00, r=8'h07; done at k+16 without the macro, k+9 with BCD_DIV_EARLY_EXIT_EN.
- start spam: start pulses at k, k+3 and in the DONE cycle → exactly one done. Changing a_bcd at k+2 does not alter the result. A start at k+17 is accepted.
- Reset mid-operation: rst_n low at k+5 for one cycle → outputs 8'hFF/8'hFF, busy=0, no done pulse. A new start afterwards completes normally.

Source files
------------

// File: rtl/bcd_seq_divider.sv
// bcd_seq_divider: two-digit BCD divider, restoring divide then double-dabble.
// Ports: clk, rst_n, start, a_bcd, b_bcd -> q_bcd, r_bcd, busy, done, div_zero, bad_digit.
// Option: define BCD_DIV_EARLY_EXIT_EN to skip DIV when dividend < divisor.
module bcd_seq_divider #(
  parameter logic [3:0] BLANK_CODE = 4'hF,
  parameter int         Q_BITS     = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a_bcd,
  input  logic [7:0] b_bcd,
  output logic [7:0] q_bcd,
  output logic [7:0] r_bcd,
  output logic       busy,
  output logic       done,
  output logic       div_zero,
  output logic       bad_digit
);
  localparam int CW = $clog2(Q_BITS);

  typedef enum logic [2:0] {
    IDLE, LOAD, DIV, CONV, DONE
  } state_t;

  state_t state, state_nx;

  logic [7:0]        a_q, b_q;
  logic [Q_BITS-1:0] dvd, dvs, rem;
  logic [Q_BITS-1:0] a_bin, b_bin;
  logic [Q_BITS:0]   rem_sh;
  logic [7:0]        qb, rb, qb_nx, rb_nx;
  logic [CW-1:0]     cnt;
  logic              last, bad, zero, early, ge;

  function automatic logic [3:0] dval(input logic [3:0] d);
    return (d == BLANK_CODE) ? 4'd0 : d;
  endfunction

  function automatic logic dbad(input logic [3:0] d);
    return (d > 4'd9) && (d != BLANK_CODE);
  endfunction

  function automatic logic [Q_BITS-1:0] to_bin(input logic [7:0] x);
    return Q_BITS'(dval(x[7:4])) * Q_BITS'(10)
         + Q_BITS'(dval(x[3:0]));
  endfunction

  // add-3 correction on each digit, then shift one binary bit in
  function automatic logic [7:0] dd_step(input logic [7:0] b,
                                         input logic       s);
    logic [3:0] t, u;
    t = b[7:4];
    u = b[3:0];
    if (t > 4'd4) t = t + 4'd3;
    if (u > 4'd4) u = u + 4'd3;
    return 8'({t, u, s});
  endfunction

  assign a_bin = to_bin(a_q);
  assign b_bin = to_bin(b_q);
  assign bad   = dbad(a_q[7:4]) | dbad(a_q[3:0])
               | dbad(b_q[7:4]) | dbad(b_q[3:0]);
  assign zero  = (b_bin == '0);
`ifdef BCD_DIV_EARLY_EXIT_EN
  assign early = (a_bin < b_bin);
`else
  assign early = 1'b0;
`endif
  assign last   = (cnt == CW'(Q_BITS - 1));
  // dvd doubles as dividend shifter and quotient collector
  assign rem_sh = {rem, dvd[Q_BITS-1]};
  assign ge     = (rem_sh >= {1'b0, dvs});
  assign qb_nx  = dd_step(qb, dvd[Q_BITS-1]);
  assign rb_nx  = dd_step(rb, rem[Q_BITS-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        if (bad || zero) state_nx = DONE;
        else if (early)  state_nx = CONV;
        else             state_nx = DIV;
      end
      DIV:  if (last) state_nx = CONV;
      CONV: if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      qb        <= '0;
      rb        <= '0;
      cnt       <= '0;
      q_bcd     <= {BLANK_CODE, BLANK_CODE};
      r_bcd     <= {BLANK_CODE, BLANK_CODE};
      div_zero  <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q <= a_bcd;
            b_q <= b_bcd;
          end
        end
        LOAD: begin
          cnt <= '0;
          qb  <= '0;
          rb  <= '0;
          if (bad || zero) begin
            bad_digit <= bad;
            div_zero  <= ~bad;
            q_bcd     <= {BLANK_CODE, BLANK_CODE};
            r_bcd     <= {BLANK_CODE, BLANK_CODE};
          end else begin
            bad_digit <= 1'b0;
            div_zero  <= 1'b0;
            dvs       <= b_bin;
            if (early) begin
              dvd <= '0;
              rem <= a_bin;
            end else begin
              dvd <= a_bin;
              rem <= '0;
            end
          end
        end
        DIV: begin
          rem <= ge ? rem_sh[Q_BITS-1:0] - dvs
                    : rem_sh[Q_BITS-1:0];
          dvd <= {dvd[Q_BITS-2:0], ge};
          cnt <= last ? '0 : cnt + 1'b1;
        end
        CONV: begin
          qb  <= qb_nx;
          rb  <= rb_nx;
          dvd <= {dvd[Q_BITS-2:0], 1'b0};
          rem <= {rem[Q_BITS-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (last) begin
            q_bcd <= qb_nx;
            r_bcd <= rb_nx;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule
